ht_cmd_arbiter: RTL and testbench
=================================

# ht_cmd_arbiter

Round-robin arbiter that shares one hash table command port between CLIENTS requesters and routes each `ht_result_t` back to the requester that issued it. It sits between the client interfaces and the hash table pipeline input/output. It tracks up to MAX_INFLIGHT outstanding commands in an in-order requester-ID FIFO. The hash table returns results in command order, so that FIFO alone determines result routing.

## Interface
- CLIENTS, 4, number of requesters, 2..16
- MAX_INFLIGHT, 16, outstanding-command limit, power of two, 2..256
- clk_i  in  1  single clock
- rst_n_i  in  1  synchronous, active-low reset
- cli_cmd_i  in  CLIENTS x $bits(ht_command_t)  per-client command (key, value, opcode)
- cli_cmd_valid_i  in  CLIENTS  per-client command valid
- cli_cmd_ready_o  out  CLIENTS  per-client command ready (one-hot or zero)
- ht_cmd_o  out  $bits(ht_command_t)  command to hash table
- ht_cmd_valid_o  out  1  command valid
- ht_cmd_ready_i  in  1  hash table accepts command
- ht_res_i  in  $bits(ht_result_t)  result from hash table
- ht_res_valid_i  in  1  result valid
- ht_res_ready_o  out  1  result accepted
- cli_res_o  out  $bits(ht_result_t)  result, broadcast to all clients
- cli_res_valid_o  out  CLIENTS  one-hot result valid for the owning client
- cli_res_ready_i  in  CLIENTS  per-client result ready
- inflight_o  out  $clog2(MAX_INFLIGHT+1)  commands granted and not yet returned
- err_o  out  1  sticky: result arrived with the ID FIFO empty

## Operation
- **Command output register.** One-entry register holding ht_cmd_o and ht_cmd_valid_o.
  - `slot_free` = !ht_cmd_valid_o || ht_cmd_ready_i.
- **Grant condition.** `can_grant` = slot_free && (inflight_o < MAX_INFLIGHT) && any cli_cmd_valid_i.
  - inflight_o is the registered value.
  - No grant when inflight_o == MAX_INFLIGHT, even if a result pops in the same cycle.
- **Round-robin selection.**
  - Search starts at `rr_ptr`, ascending with wrap.
  - The first valid client wins. Its cli_cmd_ready_o bit is asserted combinationally that cycle.
  - On grant: load the client command into the output register, set valid, push the client index into the ID FIFO, set rr_ptr = winner+1 mod CLIENTS.
  - If slot_free and no grant occurs, ht_cmd_valid_o clears.
- **Result routing** (combinational pass-through, no storage):
  - cli_res_o = ht_res_i.
  - cli_res_valid_o[id] = ht_res_valid_i && !fifo_empty, where id is the FIFO head.
  - ht_res_ready_o = cli_res_ready_i[id].
  - The FIFO pops on the ht_res_valid_i && ht_res_ready_o handshake.
- **Orphan result** (ht_res_valid_i while the FIFO is empty):
  - ht_res_ready_o = 1, so the result is dropped.
  - cli_res_valid_o = 0.
  - err_o is set and stays set until reset.
- **inflight_o.**
  - +1 on grant, −1 on result pop, unchanged when both happen in the same cycle.
  - Width rule: it never exceeds MAX_INFLIGHT and never underflows.
  - It equals the FIFO occupancy.
- **Reset** (synchronous, active-low):
  - ht_cmd_valid_o=0, ht_cmd_o=0, rr_ptr=0, FIFO empty, inflight_o=0, err_o=0.
  - cli_cmd_ready_o=0, cli_res_valid_o=0, ht_res_ready_o follows the empty-FIFO rule (=1).
  - Commands held in the slot at reset are discarded.
  - A reset mid-operation does not flush the hash table. The integrator must reset both together.

## Timing
- Command latency: client handshake in cycle N → ht_cmd_valid_o in cycle N+1.
- Throughput: one command per cycle while ht_cmd_ready_i=1 and inflight_o < MAX_INFLIGHT.
- ht_cmd_o/ht_cmd_valid_o are held stable while valid && !ready.
- Result path has zero latency: cli_res_valid_o and ht_res_ready_o follow their inputs in the same cycle.
- A command granted in cycle N can be routed a result no earlier than cycle N+1, because the FIFO is registered.
- cli_cmd_ready_o depends combinationally on cli_cmd_valid_i and ht_cmd_ready_i. Clients must not make valid depend on ready.

## Test plan
- **Fairness:** all 4 clients hold valid, ht_cmd_ready_i=1 → grants go 0,1,2,3,0,1… one per cycle; each ht_cmd_o.key matches the granted client's key.
- **Skip idle clients:** only clients 1 and 3 valid, rr_ptr=2 → grant order 3,1,3,1.
- **Backpressure:** ht_cmd_ready_i=0 for 5 cycles with client 0 valid → exactly one grant, ht_cmd_o stable, and cli_cmd_ready_o=0 for the remaining stall cycles.
- **Inflight limit:** MAX_INFLIGHT=16, no results returned → 16 grants, then inflight_o=16 and all ready low. One result pop → next grant one cycle later, with inflight_o back to 16.
- **Result routing:** issue commands from clients 2,0,2 and return three results in order, with cli_res_ready_i[0]=0 for 3 cycles → valid goes one-hot to 2, then 0 (stalled; ht_res_ready_o=0 for 3 cycles), then 2. inflight_o ends at 0.
- **Orphan and reset:** result valid with the FIFO empty → ht_res_ready_o=1, err_o=1. Assert rst_n_i=0 for one cycle with commands in flight → all outputs at reset values and err_o=0 on the next cycle.

Source files
------------

// File: rtl/ht_cmd_arbiter_if.sv
// Hash-table command/result types and the bus bundle between clients, arbiter and hash table.
// The arbiter binds the slave modport; the surrounding environment binds master.
package ht_pkg;
    typedef struct packed {
        logic [1:0]  opcode;
        logic [15:0] key;
        logic [15:0] value;
    } ht_command_t;

    typedef struct packed {
        logic        found;
        logic [15:0] key;
        logic [15:0] value;
    } ht_result_t;
endpackage

interface ht_cmd_arbiter_if #(
    parameter int CLIENTS = 4
);
    ht_pkg::ht_command_t [CLIENTS-1:0] cli_cmd_i;
    logic [CLIENTS-1:0]                cli_cmd_valid_i;
    logic [CLIENTS-1:0]                cli_cmd_ready_o;
    ht_pkg::ht_command_t               ht_cmd_o;
    logic                              ht_cmd_valid_o;
    logic                              ht_cmd_ready_i;
    ht_pkg::ht_result_t                ht_res_i;
    logic                              ht_res_valid_i;
    logic                              ht_res_ready_o;
    ht_pkg::ht_result_t                cli_res_o;
    logic [CLIENTS-1:0]                cli_res_valid_o;
    logic [CLIENTS-1:0]                cli_res_ready_i;

    modport slave (
        input  cli_cmd_i, cli_cmd_valid_i, ht_cmd_ready_i,
        input  ht_res_i, ht_res_valid_i, cli_res_ready_i,
        output cli_cmd_ready_o, ht_cmd_o, ht_cmd_valid_o,
        output ht_res_ready_o, cli_res_o, cli_res_valid_o
    );

    modport master (
        output cli_cmd_i, cli_cmd_valid_i, ht_cmd_ready_i,
        output ht_res_i, ht_res_valid_i, cli_res_ready_i,
        input  cli_cmd_ready_o, ht_cmd_o, ht_cmd_valid_o,
        input  ht_res_ready_o, cli_res_o, cli_res_valid_o
    );
endinterface

// File: rtl/ht_cmd_arbiter.sv
// Round-robin arbiter sharing one hash-table command port among CLIENTS requesters;
// an in-order requester-ID FIFO routes each returning result to its owner.
module ht_cmd_arbiter #(
    parameter int CLIENTS      = 4,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    ht_cmd_arbiter_if.slave                   bus,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
    output logic                              err_o
);
    import ht_pkg::*;

    localparam int IDW  = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
    localparam int IDW1 = IDW + 1;
    localparam int PW   = $clog2(MAX_INFLIGHT);
    localparam int CW   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0]   MAX_N   = CW'(MAX_INFLIGHT);
    localparam logic [IDW1-1:0] CLI_N   = IDW1'(CLIENTS);
    localparam logic [IDW-1:0]  LAST_ID = IDW'(CLIENTS - 1);

    ht_command_t     cmd_q, cmd_d;
    logic            cmd_vld_q, cmd_vld_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  fifo_q [MAX_INFLIGHT];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic            err_q, err_d;

    logic            slot_free;
    logic            any_valid;
    logic            can_grant;
    logic            fifo_empty;
    logic            res_ready;
    logic            pop;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  head_id;
    logic [IDW1-1:0] rr_cand;

    assign slot_free  = !cmd_vld_q || bus.ht_cmd_ready_i;
    assign any_valid  = |bus.cli_cmd_valid_i;
    assign can_grant  = slot_free && (inflight_q < MAX_N) && any_valid;
    assign fifo_empty = (inflight_q == '0);
    assign head_id    = fifo_q[rd_ptr_q];
    // An orphan result is swallowed so the hash table pipeline never stalls on it.
    assign res_ready  = fifo_empty ? 1'b1 : bus.cli_res_ready_i[head_id];
    assign pop        = bus.ht_res_valid_i && res_ready && !fifo_empty;

    // Descending scan so the valid client closest to rr_ptr is written last and wins.
    always_comb begin
        winner  = rr_ptr_q;
        rr_cand = '0;
        for (int i = CLIENTS - 1; i >= 0; i--) begin
            rr_cand = {1'b0, rr_ptr_q} + IDW1'(i);
            if (rr_cand >= CLI_N) begin
                rr_cand = rr_cand - CLI_N;
            end
            if (bus.cli_cmd_valid_i[rr_cand[IDW-1:0]]) begin
                winner = rr_cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        bus.cli_cmd_ready_o = '0;
        bus.cli_res_valid_o = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            bus.cli_cmd_ready_o[i] = can_grant && (winner == IDW'(i));
            bus.cli_res_valid_o[i] = bus.ht_res_valid_i && !fifo_empty && (head_id == IDW'(i));
        end
    end

    assign bus.ht_cmd_o       = cmd_q;
    assign bus.ht_cmd_valid_o = cmd_vld_q;
    assign bus.ht_res_ready_o = res_ready;
    assign bus.cli_res_o      = bus.ht_res_i;
    assign inflight_o         = inflight_q;
    assign err_o              = err_q;

    always_comb begin
        cmd_d      = cmd_q;
        cmd_vld_d  = cmd_vld_q;
        rr_ptr_d   = rr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q;
        err_d      = err_q || (bus.ht_res_valid_i && fifo_empty);
        if (slot_free) begin
            cmd_vld_d = can_grant;
        end
        if (can_grant) begin
            cmd_d    = bus.cli_cmd_i[winner];
            wr_ptr_d = wr_ptr_q + 1'b1;
            rr_ptr_d = (winner == LAST_ID) ? '0 : winner + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({can_grant, pop})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cmd_q      <= '0;
            cmd_vld_q  <= 1'b0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            cmd_vld_q  <= cmd_vld_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // ID storage needs no reset: occupancy is tracked by inflight_q and the pointers.
    always_ff @(posedge clk_i) begin
        if (can_grant) begin
            fifo_q[wr_ptr_q] <= winner;
        end
    end
endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// Directed bench for ht_cmd_arbiter: fairness, idle skipping, backpressure, inflight limit,
// result routing, orphan results and mid-operation reset.
module tb_ht_cmd_arbiter;
    import ht_pkg::*;

    localparam int CLIENTS      = 4;
    localparam int MAX_INFLIGHT = 16;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [4:0] inflight_o;
    logic       err_o;
    int         checks = 0;
    int         errors = 0;

    ht_cmd_arbiter_if #(.CLIENTS(CLIENTS)) bus_if ();

    ht_cmd_arbiter #(.CLIENTS(CLIENTS), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .bus        (bus_if),
        .inflight_o (inflight_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input int n);
        bus_if.ht_res_valid_i  = 1'b1;
        bus_if.cli_res_ready_i = '1;
        repeat (n) tick();
        bus_if.ht_res_valid_i  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        tick();
        tick();
        #1;
        checks++; if (bus_if.ht_cmd_valid_o !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid: got %b want 0", bus_if.ht_cmd_valid_o); end
        checks++; if (bus_if.ht_cmd_o !== 34'd0) begin errors++; $display("FAIL rst_cmd: got %h want 0", bus_if.ht_cmd_o); end
        checks++; if (inflight_o !== 5'd0) begin errors++; $display("FAIL rst_inflight: got %0d want 0", inflight_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
        checks++; if (bus_if.cli_cmd_ready_o !== 4'b0000) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0000", bus_if.cli_cmd_ready_o); end
        checks++; if (bus_if.ht_res_ready_o !== 1'b1) begin errors++; $display("FAIL rst_res_ready: got %b want 1", bus_if.ht_res_ready_o); end
        checks++; if (bus_if.cli_res_valid_o !== 4'b0000) begin errors++; $display("FAIL rst_res_valid: got %b want 0000", bus_if.cli_res_valid_o); end
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_fairness();
        logic [3:0]  exp;
        logic [15:0] exp_key;
        bus_if.cli_cmd_valid_i = 4'b1111;
        bus_if.ht_cmd_ready_i  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp     = 4'b0001 << (k % 4);
            exp_key = 16'(16'h0100 + (k % 4));
            checks++; if (bus_if.cli_cmd_ready_o !== exp) begin errors++; $display("FAIL fair_ready[%0d]: got %b want %b", k, bus_if.cli_cmd_ready_o, exp); end
            tick();
            checks++; if (bus_if.ht_cmd_valid_o !== 1'b1 || bus_if.ht_cmd_o.key !== exp_key) begin
                errors++; $display("FAIL fair_cmd[%0d]: got valid %b key %h want 1 %h", k, bus_if.ht_cmd_valid_o, bus_if.ht_cmd_o.key, exp_key);
            end
        end
        bus_if.cli_cmd_valid_i = 4'b0000;
        checks++; if (inflight_o !== 5'd8) begin errors++; $display("FAIL fair_inflight: got %0d want 8", inflight_o); end
        bus_if.ht_res_valid_i  = 1'b1;
        bus_if.cli_res_ready_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp = 4'b0001 << (k % 4);
            checks++; if (bus_if.cli_res_valid_o !== exp) begin errors++; $display("FAIL fair_route[%0d]: got %b want %b", k, bus_if.cli_res_valid_o, exp); end
            tick();
        end
        bus_if.ht_res_valid_i = 1'b0;
        #1;
        checks++; if (inflight_o !== 5'd0) begin errors++; $display("FAIL fair_drain: got %0d want 0", inflight_o); end
    endtask

    task automatic test_skip_idle();
        logic [3:0] exp;
        bus_if.cli_cmd_valid_i = 4'b0010;
        #1;
        checks++; if (bus_if.cli_cmd_ready_o !== 4'b0010) begin errors++; $display("FAIL skip_setup: got %b want 0010", bus_if.cli_cmd_ready_o); end
        tick();
        bus_if.cli_cmd_valid_i = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp = (k % 2 == 0) ? 4'b1000 : 4'b0010;
            checks++; if (bus_if.cli_cmd_ready_o !== exp) begin errors++; $display("FAIL skip_ready[%0d]: got %b want %b", k, bus_if.cli_cmd_ready_o, exp); end
            tick();
        end
        bus_if.cli_cmd_valid_i = 4'b0000;
        checks++; if (inflight_o !== 5'd5) begin errors++; $display("FAIL skip_inflight: got %0d want 5", inflight_o); end
        drain(5);
    endtask

    task automatic test_backpressure();
        logic [3:0] exp;
        int         grants;
        grants = 0;
        bus_if.cli_cmd_valid_i = 4'b0001;
        bus_if.ht_cmd_ready_i  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            exp = (c == 0) ? 4'b0001 : 4'b0000;
            if (bus_if.cli_cmd_ready_o !== 4'b0000) grants++;
            checks++; if (bus_if.cli_cmd_ready_o !== exp) begin errors++; $display("FAIL bp_ready[%0d]: got %b want %b", c, bus_if.cli_cmd_ready_o, exp); end
            tick();
            checks++; if (bus_if.ht_cmd_valid_o !== 1'b1 || bus_if.ht_cmd_o.key !== 16'h0100) begin
                errors++; $display("FAIL bp_hold[%0d]: got valid %b key %h want 1 0100", c, bus_if.ht_cmd_valid_o, bus_if.ht_cmd_o.key);
            end
        end
        checks++; if (grants !== 1) begin errors++; $display("FAIL bp_grants: got %0d want 1", grants); end
        bus_if.cli_cmd_valid_i = 4'b0000;
        bus_if.ht_cmd_ready_i  = 1'b1;
        tick();
        checks++; if (bus_if.ht_cmd_valid_o !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", bus_if.ht_cmd_valid_o); end
        checks++; if (inflight_o !== 5'd1) begin errors++; $display("FAIL bp_inflight: got %0d want 1", inflight_o); end
        drain(1);
    endtask

    task automatic test_inflight_limit();
        bus_if.cli_cmd_valid_i = 4'b0001;
        bus_if.ht_cmd_ready_i  = 1'b1;
        repeat (16) tick();
        checks++; if (inflight_o !== 5'd16) begin errors++; $display("FAIL lim_full: got %0d want 16", inflight_o); end
        checks++; if (bus_if.cli_cmd_ready_o !== 4'b0000) begin errors++; $display("FAIL lim_ready_full: got %b want 0000", bus_if.cli_cmd_ready_o); end
        bus_if.ht_res_valid_i  = 1'b1;
        bus_if.cli_res_ready_i = 4'b1111;
        #1;
        checks++; if (bus_if.cli_cmd_ready_o !== 4'b0000) begin errors++; $display("FAIL lim_ready_pop: got %b want 0000", bus_if.cli_cmd_ready_o); end
        checks++; if (bus_if.cli_res_valid_o !== 4'b0001) begin errors++; $display("FAIL lim_res_valid: got %b want 0001", bus_if.cli_res_valid_o); end
        tick();
        bus_if.ht_res_valid_i = 1'b0;
        checks++; if (inflight_o !== 5'd15) begin errors++; $display("FAIL lim_after_pop: got %0d want 15", inflight_o); end
        checks++; if (bus_if.ht_cmd_valid_o !== 1'b0) begin errors++; $display("FAIL lim_slot_idle: got %b want 0", bus_if.ht_cmd_valid_o); end
        #1;
        checks++; if (bus_if.cli_cmd_ready_o !== 4'b0001) begin errors++; $display("FAIL lim_regrant: got %b want 0001", bus_if.cli_cmd_ready_o); end
        tick();
        checks++; if (inflight_o !== 5'd16 || bus_if.ht_cmd_valid_o !== 1'b1) begin
            errors++; $display("FAIL lim_refill: got inflight %0d valid %b want 16 1", inflight_o, bus_if.ht_cmd_valid_o);
        end
        bus_if.cli_cmd_valid_i = 4'b0000;
        drain(16);
        checks++; if (inflight_o !== 5'd0) begin errors++; $display("FAIL lim_drain: got %0d want 0", inflight_o); end
    endtask

    task automatic test_result_routing();
        logic [3:0] vseq [3];
        vseq[0] = 4'b0100; vseq[1] = 4'b0001; vseq[2] = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            bus_if.cli_cmd_valid_i = vseq[k];
            #1;
            checks++; if (bus_if.cli_cmd_ready_o !== vseq[k]) begin errors++; $display("FAIL rt_grant[%0d]: got %b want %b", k, bus_if.cli_cmd_ready_o, vseq[k]); end
            tick();
        end
        bus_if.cli_cmd_valid_i = 4'b0000;
        checks++; if (inflight_o !== 5'd3) begin errors++; $display("FAIL rt_inflight: got %0d want 3", inflight_o); end
        bus_if.ht_res_i        = '{found: 1'b1, key: 16'hBEEF, value: 16'h1234};
        bus_if.ht_res_valid_i  = 1'b1;
        bus_if.cli_res_ready_i = 4'b1111;
        #1;
        checks++; if (bus_if.cli_res_valid_o !== 4'b0100 || bus_if.ht_res_ready_o !== 1'b1) begin
            errors++; $display("FAIL rt_first: got valid %b ready %b want 0100 1", bus_if.cli_res_valid_o, bus_if.ht_res_ready_o);
        end
        checks++; if (bus_if.cli_res_o !== 33'h1BEEF1234) begin errors++; $display("FAIL rt_data: got %h want 1beef1234", bus_if.cli_res_o); end
        tick();
        bus_if.cli_res_ready_i = 4'b1110;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus_if.cli_res_valid_o !== 4'b0001 || bus_if.ht_res_ready_o !== 1'b0) begin
                errors++; $display("FAIL rt_stall[%0d]: got valid %b ready %b want 0001 0", c, bus_if.cli_res_valid_o, bus_if.ht_res_ready_o);
            end
            tick();
        end
        bus_if.cli_res_ready_i = 4'b1111;
        #1;
        checks++; if (bus_if.cli_res_valid_o !== 4'b0001 || bus_if.ht_res_ready_o !== 1'b1) begin
            errors++; $display("FAIL rt_second: got valid %b ready %b want 0001 1", bus_if.cli_res_valid_o, bus_if.ht_res_ready_o);
        end
        tick();
        #1;
        checks++; if (bus_if.cli_res_valid_o !== 4'b0100) begin errors++; $display("FAIL rt_third: got %b want 0100", bus_if.cli_res_valid_o); end
        tick();
        bus_if.ht_res_valid_i = 1'b0;
        #1;
        checks++; if (inflight_o !== 5'd0) begin errors++; $display("FAIL rt_end: got %0d want 0", inflight_o); end
    endtask

    task automatic test_orphan_reset();
        bus_if.ht_res_valid_i = 1'b1;
        #1;
        checks++; if (bus_if.ht_res_ready_o !== 1'b1 || bus_if.cli_res_valid_o !== 4'b0000) begin
            errors++; $display("FAIL orph_route: got ready %b valid %b want 1 0000", bus_if.ht_res_ready_o, bus_if.cli_res_valid_o);
        end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL orph_err_pre: got %b want 0", err_o); end
        tick();
        bus_if.ht_res_valid_i = 1'b0;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL orph_err: got %b want 1", err_o); end
        tick();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL orph_sticky: got %b want 1", err_o); end
        bus_if.cli_cmd_valid_i = 4'b1111;
        bus_if.ht_cmd_ready_i  = 1'b1;
        repeat (3) tick();
        checks++; if (inflight_o !== 5'd3) begin errors++; $display("FAIL orph_inflight: got %0d want 3", inflight_o); end
        bus_if.cli_cmd_valid_i = 4'b0000;
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        checks++; if (bus_if.ht_cmd_valid_o !== 1'b0 || bus_if.ht_cmd_o !== 34'd0) begin
            errors++; $display("FAIL mid_rst_cmd: got valid %b cmd %h want 0 0", bus_if.ht_cmd_valid_o, bus_if.ht_cmd_o);
        end
        checks++; if (inflight_o !== 5'd0 || err_o !== 1'b0) begin
            errors++; $display("FAIL mid_rst_state: got inflight %0d err %b want 0 0", inflight_o, err_o);
        end
        #1;
        checks++; if (bus_if.cli_cmd_ready_o !== 4'b0000 || bus_if.ht_res_ready_o !== 1'b1 || bus_if.cli_res_valid_o !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_comb: got cready %b rready %b rvalid %b want 0000 1 0000",
                               bus_if.cli_cmd_ready_o, bus_if.ht_res_ready_o, bus_if.cli_res_valid_o);
        end
        bus_if.cli_cmd_valid_i = 4'b1111;
        #1;
        checks++; if (bus_if.cli_cmd_ready_o !== 4'b0001) begin errors++; $display("FAIL mid_rst_rr: got %b want 0001", bus_if.cli_cmd_ready_o); end
        tick();
        bus_if.cli_cmd_valid_i = 4'b0000;
        drain(1);
    endtask

    initial begin
        for (int i = 0; i < CLIENTS; i++) begin
            bus_if.cli_cmd_i[i].opcode = 2'(i);
            bus_if.cli_cmd_i[i].key    = 16'(16'h0100 + i);
            bus_if.cli_cmd_i[i].value  = 16'(16'hA000 + i);
        end
        bus_if.cli_cmd_valid_i = '0;
        bus_if.ht_cmd_ready_i  = 1'b1;
        bus_if.ht_res_i        = '0;
        bus_if.ht_res_valid_i  = 1'b0;
        bus_if.cli_res_ready_i = '1;
        rst_n_i                = 1'b0;

        test_reset();
        test_fairness();
        test_skip_idle();
        test_backpressure();
        test_inflight_limit();
        test_result_routing();
        test_orphan_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end
endmodule
